// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - size encodings, FSM state type and lane-alignment helpers for store_align_buffer
package store_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic {
        IDLE     = 1'b0,
        SPLIT_HI = 1'b1
    } state_e;

    // Byte count of a store; doubleword collapses to a word on a 32-bit datapath
    function automatic logic [3:0] size_nbytes(input size_e sz, input int xlen);
        case (sz)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            default: return (xlen == 64) ? 4'd8 : 4'd4;
        endcase
    endfunction

    // Keeps only the low nbytes bytes of the store value
    function automatic logic [63:0] size_mask(input logic [3:0] nbytes);
        case (nbytes)
            4'd1:    return 64'h0000_0000_0000_00FF;
            4'd2:    return 64'h0000_0000_0000_FFFF;
            4'd4:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Shifts sized data into its byte lanes across a two-beat window
    function automatic logic [127:0] align_data(input logic [63:0] data, input logic [2:0] off);
        return {64'd0, data} << {off, 3'b000};
    endfunction

    // Byte-lane enables across a two-beat window
    function automatic logic [15:0] align_strb(input logic [3:0] nbytes, input logic [2:0] off);
        return ((16'd1 << nbytes) - 16'd1) << off;
    endfunction

endpackage

// File: rtl/store_fifo.sv
// rtl/store_fifo.sv - circular store queue with simultaneous push/pop
module store_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Entry storage; no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/store_align_buffer.sv
// rtl/store_align_buffer.sv - store lane aligner and queue; STORE_SPLIT_EN splits misaligned stores into two beats
module store_align_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [31:0]                req_addr,
    input  logic [1:0]                 req_size,
    input  logic [XLEN-1:0]            req_data,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [31:0]                mem_addr,
    output logic [XLEN-1:0]            mem_wdata,
    output logic [XLEN/8-1:0]          mem_strb,
    output logic                       misalign_err,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    import store_pkg::*;

    localparam int NB   = XLEN/8;
    localparam int OFFW = $clog2(NB);
    localparam int EW   = 32 + XLEN + NB;

    logic [2:0]      w_off;
    logic [3:0]      w_nbytes;
    logic [63:0]     w_sized;
    logic [XLEN-1:0] w_lo_data;
    logic [2*NB-1:0] w_strb;
    logic [NB-1:0]   w_lo_strb;
    logic            w_mis;
    logic [31:0]     w_lo_addr;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [EW-1:0]   w_push_data;
    logic [EW-1:0]   w_pop_data;
    state_e          r_state;
    state_e          w_state_nxt;
    logic            r_misalign_err;

    assign w_off     = 3'(req_addr[OFFW-1:0]);
    assign w_nbytes  = size_nbytes(size_e'(req_size), XLEN);
    assign w_sized   = 64'(req_data) & size_mask(w_nbytes);
    assign w_lo_data = XLEN'(align_data(w_sized, w_off));
    assign w_strb    = (2*NB)'(align_strb(w_nbytes, w_off));
    assign w_lo_strb = w_strb[NB-1:0];
    assign w_mis     = |w_strb[2*NB-1:NB];
    assign w_lo_addr = {req_addr[31:OFFW], {OFFW{1'b0}}};

    // Ready depends only on registered state so no valid->ready loop exists
    assign req_ready    = !rst && (r_state == IDLE) && !w_full;
    assign w_accept     = req_valid && req_ready;
    assign mem_valid    = !w_empty;
    assign w_pop        = mem_valid && mem_ready;
    assign mem_addr     = w_pop_data[EW-1 -: 32];
    assign mem_wdata    = w_pop_data[NB +: XLEN];
    assign mem_strb     = w_pop_data[NB-1:0];
    assign misalign_err = r_misalign_err;

`ifdef STORE_SPLIT_EN
    logic [31:0]     r_hi_addr;
    logic [XLEN-1:0] r_hi_data;
    logic [NB-1:0]   r_hi_strb;

    // Capture the high beat of a misaligned store while the low beat is queued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi_addr <= '0;
            r_hi_data <= '0;
            r_hi_strb <= '0;
        end else if ((r_state == IDLE) && w_accept && w_mis) begin
            r_hi_addr <= w_lo_addr + 32'(NB);
            r_hi_data <= XLEN'(align_data(w_sized, w_off) >> XLEN);
            r_hi_strb <= w_strb[2*NB-1:NB];
        end
    end

    // Next state and queue push: low beat on accept, pending high beat once a slot exists
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_data = {w_lo_addr, w_lo_data, w_lo_strb};
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_push = 1'b1;
                    if (w_mis) w_state_nxt = SPLIT_HI;
                end
            end
            SPLIT_HI: begin
                w_push_data = {r_hi_addr, r_hi_data, r_hi_strb};
                if (!w_full || w_pop) begin
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end
`else
    // Misaligned stores are dropped; only aligned ones enter the queue
    always_comb begin
        w_state_nxt = IDLE;
        w_push      = w_accept && !w_mis;
        w_push_data = {w_lo_addr, w_lo_data, w_lo_strb};
    end
`endif

    // State register and one-cycle drop indication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_misalign_err <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
`ifdef STORE_SPLIT_EN
            r_misalign_err <= 1'b0;
`else
            r_misalign_err <= w_accept && w_mis;
`endif
        end
    end

    store_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (count)
    );

endmodule
